// File: rtl/adder_pkg.sv
// Shared constants for the nibble-serial adder: nibble width and FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage : adder_pkg

// File: rtl/kogge_stone_4.sv
// 4-bit Kogge-Stone parallel-prefix adder slice with carry-in.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller sequences the operands.
module kogge_stone_4
  import adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g1;
  logic [NIB_W-1:0] p1;
  logic [NIB_W-1:0] g2;

  // Two prefix levels (span 1, span 2); cin is folded into bit 0's generate.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    g1 = '0;
    p1 = '0;
    g2 = '0;
    // Level 1: bit i combines with bit i-1.
    g1[0] = g[0] | (p[0] & cin);
    p1[0] = 1'b0;
    g1[1] = g[1] | (p[1] & g1[0]);
    p1[1] = 1'b0;
    g1[2] = g[2] | (p[2] & g[1]);
    p1[2] = p[2] & p[1];
    g1[3] = g[3] | (p[3] & g[2]);
    p1[3] = p[3] & p[2];
    // Level 2: bit i combines with the group ending at bit i-2.
    g2[0] = g1[0];
    g2[1] = g1[1];
    g2[2] = g1[2] | (p1[2] & g1[0]);
    g2[3] = g1[3] | (p1[3] & g1[1]);
    s     = p ^ {g2[2:0], cin};
    cout  = g2[3];
  end

endmodule : kogge_stone_4

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single 4-bit slice.
// Latency: result valid WIDTH/4 edges after the accept edge; next accept no sooner than WIDTH/4+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] s_nib;
  logic             c_nib;
  logic             last_nib;

  // Select the current nibble pair from the latched operands.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  kogge_stone_4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (c_nib)
  );

  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  // FSM next-state and datapath updates; handshakes decoded from state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*NIB_W +: NIB_W] = s_nib;
          end
        end
        carry_d = c_nib;
        if (last_nib) begin
          // idx holds here; it only returns to 0 on the next accept.
          cout_d  = c_nib;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
// Latency: n/a.
// Backpressure: exercised via held out_ready and random gaps.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;

  logic        iv16, ir16, ov16, or16, cin16, co16;
  logic [15:0] a16, b16, s16;

  logic        iv4, ir4, ov4, or4, cin4, co4;
  logic [3:0]  a4, b4, s4;

  int checks   = 0;
  int failures = 0;

  logic [16:0] q16[$];
  logic [4:0]  q4[$];
  bit          acc16;
  bit          hold16;
  logic [16:0] held16;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard / monitor for the 16-bit instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("no_overlap16", {31'd0, ir16 & ov16}, 32'd0);
      acc16 = 1'b0;
      if (iv16 && ir16) begin
        q16.push_back({1'b0, a16} + {1'b0, b16} + {16'd0, cin16});
        acc16 = 1'b1;
      end
      if (ov16) begin
        if (hold16) chk("hold_stable16", {15'd0, co16, s16}, {15'd0, held16});
        if (or16) begin
          if (q16.size() == 0) chk("unexpected_out16", 32'd1, 32'd0);
          else chk("result16", {15'd0, co16, s16}, {15'd0, q16.pop_front()});
          hold16 = 1'b0;
        end else begin
          hold16 = 1'b1;
          held16 = {co16, s16};
        end
      end else begin
        hold16 = 1'b0;
      end
    end
  end

  // Scoreboard / monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (iv4 && ir4) q4.push_back({1'b0, a4} + {1'b0, b4} + {4'd0, cin4});
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("unexpected_out4", 32'd1, 32'd0);
        else chk("result4", {27'd0, co4, s4}, {27'd0, q4.pop_front()});
      end
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  task automatic wait_q16_empty(input string name);
    int n = 0;
    while (q16.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk(name, q16.size(), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    int   n;
    int   sent;
    int   cyc;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

    rst_n = 1'b0;
    iv16 = 0; a16 = '0; b16 = '0; cin16 = 0; or16 = 1;
    iv4 = 0; a4 = '0; b4 = '0; cin4 = 0; or4 = 1;
    hold16 = 0; held16 = '0; acc16 = 0;
    #1;
    chk("rst_in_ready", {31'd0, ir16}, 32'd1);
    chk("rst_out_valid", {31'd0, ov16}, 32'd0);
    chk("rst_sum", {15'd0, co16, s16}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven directed vectors, with latency measurement.
    for (int v = 0; v < 5; v++) begin
      a16 = vecs[v].a; b16 = vecs[v].b; cin16 = vecs[v].cin; iv16 = 1;
      or16 = 1;
      n = 0;
      @(negedge clk);
      while (!ir16 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      iv16 = 0;
      n = 0;
      while (!ov16 && n < 20) begin @(posedge clk); #1; n++; end
      chk($sformatf("latency_v%0d", v), n, 32'd4);
      chk($sformatf("vec_sum_v%0d", v), {16'd0, s16}, {16'd0, vecs[v].exp_sum});
      chk($sformatf("vec_cout_v%0d", v), {31'd0, co16}, {31'd0, vecs[v].exp_cout});
      @(posedge clk); #1;
    end
    wait_q16_empty("drain_vec");

    // Backpressure: result held, new operands refused until transfer.
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 0; iv16 = 1; or16 = 0;
    @(posedge clk); #1;
    iv16 = 0;
    n = 0;
    while (!ov16 && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_out_valid", {31'd0, ov16}, 32'd1);
    a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1; iv16 = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, ir16}, 32'd0);
      chk("bp_queue", q16.size(), 32'd1);
      @(posedge clk); #1;
    end
    chk("bp_sum_held", {16'd0, s16}, 32'h3333);
    or16 = 1;
    @(posedge clk); #1;
    chk("bp_idle_next", {31'd0, ir16}, 32'd1);
    @(posedge clk); #1;
    iv16 = 0;
    chk("bp_pending_accepted", q16.size(), 32'd1);
    wait_q16_empty("drain_bp");
    @(posedge clk); #1;

    // Reset two cycles into RUN aborts the operation with no output.
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 0; iv16 = 1;
    @(posedge clk); #1;
    iv16 = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q16.delete();
    #1;
    chk("mid_rst_out_valid", {31'd0, ov16}, 32'd0);
    chk("mid_rst_sum", {16'd0, s16}, 32'd0);
    chk("mid_rst_cout", {31'd0, co16}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, ir16}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, ir16}, 32'd1);

    // Random traffic with random in_valid / out_ready gaps.
    sent = 0; cyc = 0;
    iv16 = 0;
    while (sent < 2000 && cyc < 40000) begin
      @(posedge clk); #1;
      cyc++;
      if (acc16) sent++;
      if (!iv16 || acc16) begin
        iv16  = 1'($urandom_range(0, 1));
        a16   = 16'($urandom);
        b16   = 16'($urandom);
        cin16 = 1'($urandom_range(0, 1));
      end
      or16 = 1'($urandom_range(0, 1));
    end
    chk("random_ops_done", {31'd0, sent >= 2000}, 32'd1);
    iv16 = 0; or16 = 1;
    wait_q16_empty("drain_random");

    // Exhaustive WIDTH=4: out_valid one edge after the accept edge.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] idx;
      idx = 9'(i);
      a4 = idx[3:0]; b4 = idx[7:4]; cin4 = idx[8]; iv4 = 1;
      n = 0;
      @(negedge clk);
      while (!ir4 && n < 10) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      iv4 = 0;
      @(posedge clk); #1;
      if (i % 64 == 0 || !ov4) chk("lat4", {31'd0, ov4}, 32'd1);
      @(posedge clk); #1;
    end
    n = 0;
    while (q4.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("drain4", q4.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nibble_serial_adder
